mp3_frame_sync: RTL and testbench
=================================

MP3_FRAME_SYNC -- requirements
Module: mp3_frame_sync

Interface
REQ-001: Parameter SYNC_LOST_EN, default 1; 1 enables the sync_lost pulse, 0 ties it low.
REQ-002: Ports, one per line; reset is asynchronous and active-high:
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  in_data  in  8  byte stream from ETH receive buffer
  in_valid  in  1  in_data valid
  in_ready  out  1  byte accepted when in_valid & in_ready
  out_data  out  8  payload byte to Huffman stage (side info + main data)
  out_valid  out  1  out_data valid
  out_ready  in  1  downstream accepts
  out_first  out  1  marks first payload byte of a frame
  out_last  out  1  marks last payload byte of a frame
  hdr_bitrate_idx  out  4  held header field
  hdr_fs_idx  out  2  held header field
  hdr_mode  out  2  held header field
  hdr_mode_ext  out  2  held header field
  hdr_padding  out  1  held header field
  hdr_protect  out  1  protection bit (0 = CRC present)
  frame_bytes  out  11  total frame length in bytes including header
  done  out  1  high when idle/searching, low while a frame payload is in flight
  sync_lost  out  1  one-cycle pulse on loss of lock
  frame_count  out  16  count of completed frames, wraps

Function
REQ-003: States: SEARCH, GOT_FF, HDR2, HDR3, CRC, PAYLOAD.
REQ-004: In SEARCH, GOT_FF, HDR2, HDR3 and CRC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-005: SEARCH -> GOT_FF on accepted byte 0xFF; otherwise remain.
REQ-006: GOT_FF accepts only 0xFA or 0xFB (sync, MPEG-1, Layer III) -> HDR2; byte 0xFF stays in GOT_FF; any other byte -> SEARCH.
REQ-007: HDR2 byte latches bitrate_idx[7:4], fs_idx[3:2], padding[1]; bitrate_idx 0 or 15, or fs_idx 3 -> SEARCH (or GOT_FF if byte is 0xFF); else -> HDR3.
REQ-008: HDR3 byte latches mode[7:6], mode_ext[5:4]; -> CRC if protect=0, else -> PAYLOAD.
REQ-009: Header outputs SHALL update only when a header is fully validated (HDR3 accept); a rejected header SHALL leave the previous values.
REQ-010: frame_bytes = floor(144*bitrate/fs) + padding via LUT; e.g. 128 kbps/44.1 kHz = 417, /48 kHz = 384, /32 kHz = 576.
REQ-011: CRC consumes exactly 2 bytes, not forwarded, then -> PAYLOAD.
REQ-012: Payload length = frame_bytes - 4 - (protect ? 0 : 2); 11-bit down-counter loaded at HDR3 accept.
REQ-013: In PAYLOAD: out_data = in_data, out_valid = in_valid, in_ready = out_ready (zero latency, combinational pass-through); counter decrements on each transfer.
REQ-014: out_first asserted with first payload byte, out_last with the byte bringing the counter to 0; both qualified by out_valid.
REQ-015: After out_last transfer -> SEARCH with lock flag set; frame_count increments by 1 on that transfer.
REQ-016: With lock set, if the first accepted byte in SEARCH is not 0xFF, or GOT_FF rejects, sync_lost SHALL pulse once and lock clears; no further pulse until relocked.
REQ-017: done falls on the cycle after HDR3 accept and rises on the cycle after the out_last transfer.
REQ-018: in_valid low or out_ready low in PAYLOAD SHALL stall without changing state or counter.

Reset
REQ-019: Reset SHALL asynchronously force SEARCH, lock=0, done=1, sync_lost=0, frame_count=0, counter=0, all hdr_* and frame_bytes to 0.
REQ-020: Reset mid-PAYLOAD SHALL abort the frame with no out_last and no frame_count increment.

Structure
REQ-021: Package mp3_sync_pkg SHALL hold the state enum, sync byte constants (0xFF, 0xFA, 0xFB), and the 14x3 frame-length LUT function.
REQ-022: No sub-module; single module with one state register block and one counter block.

Verification
REQ-023: Two back-to-back 128 kbps/44.1 kHz frames, protect=1, pad 0 -> 413 payload bytes each, out_first/out_last correct, frame_count=2, no sync_lost.
REQ-024: Frame with protect=0, 48 kHz, 128 kbps -> 2 CRC bytes dropped, 378 payload bytes forwarded.
REQ-025: Leading garbage 0x12, 0xFF, 0xFF, 0xFB, header -> locks on second 0xFF; bitrate_idx 15 header rejected, hdr_* unchanged.
REQ-026: out_ready toggled every other cycle during payload -> no lost/duplicated bytes, done low throughout payload.
REQ-027: Locked stream followed by byte 0x00 -> single sync_lost pulse, resync on next valid header.
REQ-028: Reset asserted at payload byte 100 -> all outputs at reset values immediately, next frame decoded normally.

Source files
------------

// File: rtl/mp3_sync_pkg.sv
// mp3_sync_pkg: shared definitions for the MPEG-1 Layer III frame sync block.
//   state_t    - frame parser states
//   SYNC_*     - sync byte constants (first header byte, second byte with/without CRC)
//   frame_len  - total frame length in bytes from bitrate index, fs index and padding
package mp3_sync_pkg;

  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_GOT_FF  = 3'd1,
    ST_HDR2    = 3'd2,
    ST_HDR3    = 3'd3,
    ST_CRC     = 3'd4,
    ST_PAYLOAD = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_FF = 8'hFF;
  localparam logic [7:0] SYNC_FA = 8'hFA;  // MPEG-1 Layer III, CRC present
  localparam logic [7:0] SYNC_FB = 8'hFB;  // MPEG-1 Layer III, no CRC

  // floor(144 * bitrate / fs) + padding. Columns are fs index 0/1/2 = 44.1/48/32 kHz.
  // Indices 0 and 15 are rejected before this is consulted, so they return 0.
  function automatic logic [10:0] frame_len(input logic [3:0] br,
                                            input logic [1:0] fs,
                                            input logic       pad);
    logic [10:0] base;
    base = 11'd0;
    case (br)
      4'd1:  base = (fs == 2'd0) ? 11'd104  : (fs == 2'd1) ? 11'd96  : 11'd144;
      4'd2:  base = (fs == 2'd0) ? 11'd130  : (fs == 2'd1) ? 11'd120 : 11'd180;
      4'd3:  base = (fs == 2'd0) ? 11'd156  : (fs == 2'd1) ? 11'd144 : 11'd216;
      4'd4:  base = (fs == 2'd0) ? 11'd182  : (fs == 2'd1) ? 11'd168 : 11'd252;
      4'd5:  base = (fs == 2'd0) ? 11'd208  : (fs == 2'd1) ? 11'd192 : 11'd288;
      4'd6:  base = (fs == 2'd0) ? 11'd261  : (fs == 2'd1) ? 11'd240 : 11'd360;
      4'd7:  base = (fs == 2'd0) ? 11'd313  : (fs == 2'd1) ? 11'd288 : 11'd432;
      4'd8:  base = (fs == 2'd0) ? 11'd365  : (fs == 2'd1) ? 11'd336 : 11'd504;
      4'd9:  base = (fs == 2'd0) ? 11'd417  : (fs == 2'd1) ? 11'd384 : 11'd576;
      4'd10: base = (fs == 2'd0) ? 11'd522  : (fs == 2'd1) ? 11'd480 : 11'd720;
      4'd11: base = (fs == 2'd0) ? 11'd626  : (fs == 2'd1) ? 11'd576 : 11'd864;
      4'd12: base = (fs == 2'd0) ? 11'd731  : (fs == 2'd1) ? 11'd672 : 11'd1008;
      4'd13: base = (fs == 2'd0) ? 11'd835  : (fs == 2'd1) ? 11'd768 : 11'd1152;
      4'd14: base = (fs == 2'd0) ? 11'd1044 : (fs == 2'd1) ? 11'd960 : 11'd1440;
      default: base = 11'd0;
    endcase
    return base + {10'd0, pad};
  endfunction

endpackage

// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: locks onto MPEG-1 Layer III frame headers in a byte stream,
// strips the 4-byte header and optional 2-byte CRC, and forwards the payload
// (side info + main data) with first/last markers.
//   clock, reset              - rising-edge clock, async active-high reset
//   in_data/in_valid/in_ready - input byte stream
//   out_data/out_valid/out_ready/out_first/out_last - payload stream
//   hdr_*, frame_bytes        - fields of the last fully validated header
//   done                      - high while idle/searching, low during a payload
//   sync_lost                 - one-cycle pulse when an established lock is lost
//   frame_count               - completed frames, wraps
module mp3_frame_sync
  import mp3_sync_pkg::*;
#(
  parameter bit SYNC_LOST_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [3:0]  hdr_bitrate_idx,
  output logic [1:0]  hdr_fs_idx,
  output logic [1:0]  hdr_mode,
  output logic [1:0]  hdr_mode_ext,
  output logic        hdr_padding,
  output logic        hdr_protect,
  output logic [10:0] frame_bytes,
  output logic        done,
  output logic        sync_lost,
  output logic [15:0] frame_count
);

  state_t      state;
  logic        lock;
  logic        crc_second;  // second CRC byte is next
  logic        first_pend;  // next payload transfer is the first of the frame
  logic [10:0] cnt;

  // Header fields held here until HDR3 validates the whole header
  logic [3:0]  br_q;
  logic [1:0]  fs_q;
  logic        pad_q;
  logic        prot_q;

  logic        accept;
  logic        hdr2_ok;
  logic        lost_evt;
  logic [10:0] flen;
  logic [10:0] pay_len;

  assign accept  = in_valid & in_ready;
  assign hdr2_ok = (in_data[7:4] != 4'd0) && (in_data[7:4] != 4'd15) && (in_data[3:2] != 2'd3);
  assign flen    = frame_len(br_q, fs_q, pad_q);
  assign pay_len = flen - 11'd4 - (prot_q ? 11'd0 : 11'd2);

  // Payload is a zero-latency pass-through; backpressure flows straight upstream.
  always_comb begin
    in_ready  = (state == ST_PAYLOAD) ? out_ready : 1'b1;
    out_valid = (state == ST_PAYLOAD) & in_valid;
    out_data  = in_data;
    out_first = out_valid & first_pend;
    out_last  = out_valid & (cnt == 11'd1);
  end

  // Loss of lock: after a completed frame the next byte must start a new header.
  // A repeated 0xFF in GOT_FF is still a candidate sync, not a rejection.
  always_comb begin
    lost_evt = 1'b0;
    if (lock && accept) begin
      if (state == ST_SEARCH && in_data != SYNC_FF)
        lost_evt = 1'b1;
      if (state == ST_GOT_FF && in_data != SYNC_FA && in_data != SYNC_FB && in_data != SYNC_FF)
        lost_evt = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_SEARCH;
      lock            <= 1'b0;
      crc_second      <= 1'b0;
      first_pend      <= 1'b0;
      br_q            <= '0;
      fs_q            <= '0;
      pad_q           <= 1'b0;
      prot_q          <= 1'b0;
      hdr_bitrate_idx <= '0;
      hdr_fs_idx      <= '0;
      hdr_mode        <= '0;
      hdr_mode_ext    <= '0;
      hdr_padding     <= 1'b0;
      hdr_protect     <= 1'b0;
      frame_bytes     <= '0;
      done            <= 1'b1;
      sync_lost       <= 1'b0;
      frame_count     <= '0;
    end else begin
      sync_lost <= SYNC_LOST_EN & lost_evt;
      if (lost_evt)
        lock <= 1'b0;
      if (accept) begin
        case (state)
          ST_SEARCH: begin
            if (in_data == SYNC_FF)
              state <= ST_GOT_FF;
          end
          ST_GOT_FF: begin
            if (in_data == SYNC_FA || in_data == SYNC_FB) begin
              prot_q <= in_data[0];
              state  <= ST_HDR2;
            end else if (in_data != SYNC_FF) begin
              state <= ST_SEARCH;
            end
          end
          ST_HDR2: begin
            br_q  <= in_data[7:4];
            fs_q  <= in_data[3:2];
            pad_q <= in_data[1];
            if (hdr2_ok)
              state <= ST_HDR3;
            else if (in_data == SYNC_FF)
              state <= ST_GOT_FF;
            else
              state <= ST_SEARCH;
          end
          ST_HDR3: begin
            hdr_bitrate_idx <= br_q;
            hdr_fs_idx      <= fs_q;
            hdr_padding     <= pad_q;
            hdr_protect     <= prot_q;
            hdr_mode        <= in_data[7:6];
            hdr_mode_ext    <= in_data[5:4];
            frame_bytes     <= flen;
            done            <= 1'b0;
            first_pend      <= 1'b1;
            crc_second      <= 1'b0;
            state           <= prot_q ? ST_PAYLOAD : ST_CRC;
          end
          ST_CRC: begin
            crc_second <= 1'b1;
            if (crc_second)
              state <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            first_pend <= 1'b0;
            if (cnt == 11'd1) begin
              state       <= ST_SEARCH;
              lock        <= 1'b1;
              done        <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  // Payload down-counter: loaded on the last header byte, one step per transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (accept && state == ST_HDR3)
      cnt <= pay_len;
    else if (accept && state == ST_PAYLOAD)
      cnt <= cnt - 11'd1;
  end

endmodule

// File: tb/tb_mp3_frame_sync.sv
// tb_mp3_frame_sync: random-handshake bench for mp3_frame_sync. Frames are built
// from header parameters; expected payload and frame length come from the
// bitrate/sample-rate arithmetic, not from a table.
module tb_mp3_frame_sync;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic [3:0]  hdr_bitrate_idx;
  logic [1:0]  hdr_fs_idx;
  logic [1:0]  hdr_mode;
  logic [1:0]  hdr_mode_ext;
  logic        hdr_padding;
  logic        hdr_protect;
  logic [10:0] frame_bytes;
  logic        done;
  logic        sync_lost;
  logic [15:0] frame_count;

  mp3_frame_sync dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last),
    .hdr_bitrate_idx(hdr_bitrate_idx), .hdr_fs_idx(hdr_fs_idx),
    .hdr_mode(hdr_mode), .hdr_mode_ext(hdr_mode_ext),
    .hdr_padding(hdr_padding), .hdr_protect(hdr_protect),
    .frame_bytes(frame_bytes), .done(done), .sync_lost(sync_lost),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic [3:0]  br;
    logic [1:0]  fs;
    logic        pad;
    logic        prot;
    logic [1:0]  mode;
    logic [1:0]  mext;
    logic [10:0] fb;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];

  int kbps_tab[15] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
  int fs_tab[3]    = '{44100, 48000, 32000};

  int n_chk = 0, n_pass = 0;
  int lost_seen = 0, exp_lost = 0, exp_frames = 0;
  int xfer_cnt = 0;
  bit ready_mode = 1'b0;
  exp_t last_hdr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic add_frame(input int br, input int fs, input int pad, input int prot);
    exp_t e;
    int fb, plen;
    logic [7:0] b;
    e = '0;
    e.br   = br[3:0];
    e.fs   = fs[1:0];
    e.pad  = pad[0];
    e.prot = prot[0];
    e.mode = 2'($urandom_range(0, 3));
    e.mext = 2'($urandom_range(0, 3));
    fb     = (144000 * kbps_tab[br]) / fs_tab[fs] + pad;
    e.fb   = fb[10:0];
    plen   = fb - 4 - ((prot != 0) ? 0 : 2);
    tx_q.push_back(8'hFF);
    tx_q.push_back((prot != 0) ? 8'hFB : 8'hFA);
    b = {e.br, e.fs, e.pad, 1'($urandom_range(0, 1))};
    tx_q.push_back(b);
    b = {e.mode, e.mext, 4'($urandom_range(0, 15))};
    tx_q.push_back(b);
    if (prot == 0) repeat (2) tx_q.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) begin
      e.data  = 8'($urandom);
      e.first = (i == 0);
      e.last  = (i == plen - 1);
      exp_q.push_back(e);
      tx_q.push_back(e.data);
    end
    last_hdr = e;
    exp_frames++;
  endtask

  task automatic add_garbage(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 254)));
  endtask

  // Drives tx_q with random valid/ready, scoreboards every output transfer.
  // abort_at > 0 returns right after that many payload transfers.
  task automatic run(input int abort_at);
    int  cyc = 0;
    int  tail = 0;
    bit  rt = 1'b0;
    exp_t e;
    xfer_cnt = 0;
    while (tx_q.size() > 0 || exp_q.size() > 0 || tail < 4) begin
      if (tx_q.size() == 0 && exp_q.size() == 0) tail++;
      @(negedge clock);
      in_valid  = (tx_q.size() > 0) && ($urandom_range(0, 99) < 75);
      in_data   = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
      out_ready = ready_mode ? rt : ($urandom_range(0, 99) < 70);
      rt = ~rt;
      #1;
      if (sync_lost) lost_seen++;
      if (in_valid && in_ready) tx_q.delete(0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("data",  32'(out_data),  32'(e.data));
          chk("first", 32'(out_first), 32'(e.first));
          chk("last",  32'(out_last),  32'(e.last));
          chk("done_low", 32'(done), 32'd0);
          if (e.first) begin
            chk("hdr_br",   32'(hdr_bitrate_idx), 32'(e.br));
            chk("hdr_fs",   32'(hdr_fs_idx),      32'(e.fs));
            chk("hdr_pad",  32'(hdr_padding),     32'(e.pad));
            chk("hdr_prot", 32'(hdr_protect),     32'(e.prot));
            chk("hdr_mode", 32'(hdr_mode),        32'(e.mode));
            chk("hdr_mext", 32'(hdr_mode_ext),    32'(e.mext));
            chk("frame_bytes", 32'(frame_bytes),  32'(e.fb));
          end
        end
      end
      cyc++;
      if (cyc > 30000) begin
        chk("timeout", 32'(cyc), 32'd30000);
        break;
      end
      if (abort_at > 0 && xfer_cnt == abort_at) begin
        @(posedge clock);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fc"},   32'(frame_count), 32'd0);
    chk({tag, "_fb"},   32'(frame_bytes), 32'd0);
    chk({tag, "_hdr"},  32'({hdr_bitrate_idx, hdr_fs_idx, hdr_mode, hdr_mode_ext, hdr_padding, hdr_protect}), 32'd0);
    chk({tag, "_ovld"}, 32'(out_valid), 32'd0);
    chk({tag, "_irdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_lost"}, 32'(sync_lost), 32'd0);
  endtask

  task automatic chk_totals(input string tag);
    chk({tag, "_frames"}, 32'(frame_count), 32'(exp_frames % 65536));
    chk({tag, "_lost"}, 32'(lost_seen), 32'(exp_lost));
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clock);
    in_valid = 1'b1;  // in_valid high while reset: outputs must still be idle
    #1;
    chk_reset_state("rst");
    in_valid = 1'b0;
    reset = 1'b0;

    // Two back-to-back 128 kbps / 44.1 kHz frames, no CRC, no padding
    add_frame(9, 0, 0, 1);
    add_frame(9, 0, 0, 1);
    run(0);
    chk("pay_2x413", 32'(xfer_cnt), 32'd826);
    chk("fb_417", 32'(frame_bytes), 32'd417);
    chk_totals("b2b");

    // CRC-protected 128 kbps / 48 kHz frame
    add_frame(9, 1, 0, 0);
    run(0);
    chk("pay_378", 32'(xfer_cnt), 32'd378);
    chk("fb_384", 32'(frame_bytes), 32'd384);
    chk_totals("crc");

    // Leading garbage then a double 0xFF; followed by a bitrate-15 header.
    // The 0x12 arrives while locked, so it costs one sync_lost pulse.
    tx_q.push_back(8'h12);
    tx_q.push_back(8'hFF);
    add_frame(9, 2, 1, 1);
    exp_lost++;
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hFB);
    tx_q.push_back(8'hF0);
    run(0);
    chk("fb_577", 32'(frame_bytes), 32'd577);
    chk("keep_br",  32'(hdr_bitrate_idx), 32'(last_hdr.br));
    chk("keep_fs",  32'(hdr_fs_idx),      32'(last_hdr.fs));
    chk("keep_pad", 32'(hdr_padding),     32'(last_hdr.pad));
    chk("keep_mode", 32'({hdr_mode, hdr_mode_ext}), 32'({last_hdr.mode, last_hdr.mext}));
    chk_totals("garb");

    // out_ready toggling every cycle
    ready_mode = 1'b1;
    add_frame($urandom_range(1, 14), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
    run(0);
    ready_mode = 1'b0;
    chk_totals("toggle");

    // Lock lost on a stray 0x00, then resync
    add_frame(5, 1, 0, 1);
    tx_q.push_back(8'h00);
    exp_lost++;
    add_frame(3, 2, 1, 0);
    run(0);
    chk_totals("lost");

    // Random frames with optional non-sync garbage gaps
    for (int f = 0; f < 6; f++) begin
      int g;
      g = $urandom_range(0, 3);
      if (g > 0) exp_lost++;
      add_garbage(g);
      add_frame($urandom_range(1, 14), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    run(0);
    chk_totals("rand");

    // Reset in the middle of a payload
    add_frame(9, 0, 0, 1);
    run(100);
    chk("abort_at", 32'(xfer_cnt), 32'd100);
    #2;
    in_valid = 1'b1; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk_reset_state("mid");
    tx_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_frames = 0; exp_lost = 0; lost_seen = 0;
    add_frame($urandom_range(1, 14), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
    run(0);
    chk_totals("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
